// File: rtl/mips_defs.sv
// Shared MIPS datapath constants: widths, control-word bit positions and ALU operation codes.
package mips_defs;

   localparam int MIPS_DW   = 32;
   localparam int MIPS_AW   = 5;
   localparam int MIPS_OPW  = 4;
   localparam int MIPS_CNTW = 16;

   // Bit positions inside the 8-bit control word {REGWR,MEMRD,MEMWR,MEMTOREG,ALUSRC,REGDST,BRANCH,JUMP}
   typedef enum int unsigned {
      CTRL_JUMP     = 0,
      CTRL_BRANCH   = 1,
      CTRL_REGDST   = 2,
      CTRL_ALUSRC   = 3,
      CTRL_MEMTOREG = 4,
      CTRL_MEMWR    = 5,
      CTRL_MEMRD    = 6,
      CTRL_REGWR    = 7
   } ctrl_bit_e;

   typedef enum logic [MIPS_OPW-1:0] {
      ALUOP_ADD = 4'h0,
      ALUOP_SUB = 4'h1,
      ALUOP_AND = 4'h2,
      ALUOP_OR  = 4'h3,
      ALUOP_XOR = 4'h4,
      ALUOP_NOR = 4'h5,
      ALUOP_SLT = 4'h6,
      ALUOP_SLL = 4'h7,
      ALUOP_SRL = 4'h8,
      ALUOP_SRA = 4'h9,
      ALUOP_LUI = 4'hA
   } aluop_e;

endpackage

// File: rtl/idex_hazard_detect.sv
// Combinational load-use hazard check between the load sitting in EX and the instruction in ID.
module idex_hazard_detect
   import mips_defs::*;
#(
   parameter int AW = MIPS_AW
) (
   input  logic          ex_valid_i,
   input  logic          ex_memrd_i,
   input  logic [AW-1:0] ex_wreg_i,
   input  logic          id_valid_i,
   input  logic [AW-1:0] id_rs_i,
   input  logic [AW-1:0] id_rt_i,
   input  logic          id_uses_rt_i,
   output logic          haz_o
);

   logic rs_match;
   logic rt_match;

   assign rs_match = (ex_wreg_i == id_rs_i);
   assign rt_match = id_uses_rt_i & (ex_wreg_i == id_rt_i);

   // $0 is hard-wired, so a load targeting it can never create a dependency
   assign haz_o = ex_valid_i & ex_memrd_i & (ex_wreg_i != '0) & id_valid_i
                & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional same-cycle writeback bypass into A/B when IDEX_WB_BYPASS_EN is defined.
module id_ex_stage
   import mips_defs::*;
#(
   parameter int DW   = MIPS_DW,
   parameter int AW   = MIPS_AW,
   parameter int OPW  = MIPS_OPW,
   parameter int CNTW = MIPS_CNTW
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            I_IDEX_VALID,
   input  logic [AW-1:0]   I_IDEX_RS,
   input  logic [AW-1:0]   I_IDEX_RT,
   input  logic [AW-1:0]   I_IDEX_RD,
   input  logic            I_IDEX_USES_RT,
   input  logic [DW-1:0]   I_IDEX_READ_DATA_1,
   input  logic [DW-1:0]   I_IDEX_READ_DATA_2,
   input  logic [DW-1:0]   I_IDEX_IMM,
   input  logic [DW-1:0]   I_IDEX_PC4,
   input  logic [7:0]      I_IDEX_CTRL,
   input  logic [OPW-1:0]  I_IDEX_ALUOP,
   input  logic            I_IDEX_FLUSH,
   input  logic            I_IDEX_HOLD,
   input  logic            I_WB_REGWR,
   input  logic [AW-1:0]   I_WB_RD,
   input  logic [DW-1:0]   I_WB_DATA,
   output logic            O_IDEX_STALL,
   output logic            O_IDEX_VALID,
   output logic [DW-1:0]   O_IDEX_A,
   output logic [DW-1:0]   O_IDEX_B,
   output logic [DW-1:0]   O_IDEX_IMM,
   output logic [DW-1:0]   O_IDEX_PC4,
   output logic [AW-1:0]   O_IDEX_RS,
   output logic [AW-1:0]   O_IDEX_RT,
   output logic [AW-1:0]   O_IDEX_WREG,
   output logic [7:0]      O_IDEX_CTRL,
   output logic [OPW-1:0]  O_IDEX_ALUOP,
   output logic [CNTW-1:0] O_IDEX_STALL_CNT
);

   logic            valid_q, valid_d;
   logic [DW-1:0]   a_q, a_d;
   logic [DW-1:0]   b_q, b_d;
   logic [DW-1:0]   imm_q, imm_d;
   logic [DW-1:0]   pc4_q, pc4_d;
   logic [AW-1:0]   rs_q, rs_d;
   logic [AW-1:0]   rt_q, rt_d;
   logic [AW-1:0]   wreg_q, wreg_d;
   logic [7:0]      ctrl_q, ctrl_d;
   logic [OPW-1:0]  aluop_q, aluop_d;
   logic [CNTW-1:0] cnt_q, cnt_d;

   logic            haz;
   logic [DW-1:0]   op_a;
   logic [DW-1:0]   op_b;
   logic [AW-1:0]   id_wreg;

   idex_hazard_detect #(
      .AW (AW)
   ) u_haz (
      .ex_valid_i   (valid_q),
      .ex_memrd_i   (ctrl_q[CTRL_MEMRD]),
      .ex_wreg_i    (wreg_q),
      .id_valid_i   (I_IDEX_VALID),
      .id_rs_i      (I_IDEX_RS),
      .id_rt_i      (I_IDEX_RT),
      .id_uses_rt_i (I_IDEX_USES_RT),
      .haz_o        (haz)
   );

   assign O_IDEX_STALL = haz | I_IDEX_HOLD;
   assign id_wreg      = I_IDEX_CTRL[CTRL_REGDST] ? I_IDEX_RD : I_IDEX_RT;

`ifdef IDEX_WB_BYPASS_EN
   // The register file read does not yet see a write landing this same cycle
   assign op_a = (I_WB_REGWR && (I_WB_RD != '0) && (I_WB_RD == I_IDEX_RS)) ? I_WB_DATA
                                                                         : I_IDEX_READ_DATA_1;
   assign op_b = (I_WB_REGWR && (I_WB_RD != '0) && (I_WB_RD == I_IDEX_RT)) ? I_WB_DATA
                                                                         : I_IDEX_READ_DATA_2;
`else
   logic unused_wb;
   assign unused_wb = ^{I_WB_REGWR, I_WB_RD, I_WB_DATA};
   assign op_a      = I_IDEX_READ_DATA_1;
   assign op_b      = I_IDEX_READ_DATA_2;
`endif

   always_comb begin
      valid_d = valid_q;
      a_d     = a_q;
      b_d     = b_q;
      imm_d   = imm_q;
      pc4_d   = pc4_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      wreg_d  = wreg_q;
      ctrl_d  = ctrl_q;
      aluop_d = aluop_q;
      cnt_d   = cnt_q;
      if (I_IDEX_FLUSH) begin
         // Flush beats hold and hazard; data fields still load so EX sees no stale operands
         valid_d = 1'b0;
         ctrl_d  = '0;
         aluop_d = '0;
         a_d     = op_a;
         b_d     = op_b;
         imm_d   = I_IDEX_IMM;
         pc4_d   = I_IDEX_PC4;
         rs_d    = I_IDEX_RS;
         rt_d    = I_IDEX_RT;
         wreg_d  = id_wreg;
      end else if (I_IDEX_HOLD) begin
         valid_d = valid_q;
      end else if (haz) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
         aluop_d = '0;
         cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end else begin
         valid_d = I_IDEX_VALID;
         ctrl_d  = I_IDEX_VALID ? I_IDEX_CTRL : 8'h00;
         aluop_d = I_IDEX_ALUOP;
         a_d     = op_a;
         b_d     = op_b;
         imm_d   = I_IDEX_IMM;
         pc4_d   = I_IDEX_PC4;
         rs_d    = I_IDEX_RS;
         rt_d    = I_IDEX_RT;
         wreg_d  = id_wreg;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         pc4_q   <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         wreg_q  <= '0;
         ctrl_q  <= '0;
         aluop_q <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         imm_q   <= imm_d;
         pc4_q   <= pc4_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         wreg_q  <= wreg_d;
         ctrl_q  <= ctrl_d;
         aluop_q <= aluop_d;
         cnt_q   <= cnt_d;
      end
   end

   assign O_IDEX_VALID     = valid_q;
   assign O_IDEX_A         = a_q;
   assign O_IDEX_B         = b_q;
   assign O_IDEX_IMM       = imm_q;
   assign O_IDEX_PC4       = pc4_q;
   assign O_IDEX_RS        = rs_q;
   assign O_IDEX_RT        = rt_q;
   assign O_IDEX_WREG      = wreg_q;
   assign O_IDEX_CTRL      = ctrl_q;
   assign O_IDEX_ALUOP     = aluop_q;
   assign O_IDEX_STALL_CNT = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized + directed bench for id_ex_stage against a behavioural model of the EX latch.
module tb_id_ex_stage;
   import mips_defs::*;

   logic        CLK;
   logic        RESET;
   logic        I_IDEX_VALID;
   logic [4:0]  I_IDEX_RS, I_IDEX_RT, I_IDEX_RD;
   logic        I_IDEX_USES_RT;
   logic [31:0] I_IDEX_READ_DATA_1, I_IDEX_READ_DATA_2, I_IDEX_IMM, I_IDEX_PC4;
   logic [7:0]  I_IDEX_CTRL;
   logic [3:0]  I_IDEX_ALUOP;
   logic        I_IDEX_FLUSH, I_IDEX_HOLD;
   logic        I_WB_REGWR;
   logic [4:0]  I_WB_RD;
   logic [31:0] I_WB_DATA;
   logic        O_IDEX_STALL, O_IDEX_VALID;
   logic [31:0] O_IDEX_A, O_IDEX_B, O_IDEX_IMM, O_IDEX_PC4;
   logic [4:0]  O_IDEX_RS, O_IDEX_RT, O_IDEX_WREG;
   logic [7:0]  O_IDEX_CTRL;
   logic [3:0]  O_IDEX_ALUOP;
   logic [15:0] O_IDEX_STALL_CNT;

   id_ex_stage dut (
      .CLK (CLK), .RESET (RESET),
      .I_IDEX_VALID (I_IDEX_VALID), .I_IDEX_RS (I_IDEX_RS), .I_IDEX_RT (I_IDEX_RT),
      .I_IDEX_RD (I_IDEX_RD), .I_IDEX_USES_RT (I_IDEX_USES_RT),
      .I_IDEX_READ_DATA_1 (I_IDEX_READ_DATA_1), .I_IDEX_READ_DATA_2 (I_IDEX_READ_DATA_2),
      .I_IDEX_IMM (I_IDEX_IMM), .I_IDEX_PC4 (I_IDEX_PC4), .I_IDEX_CTRL (I_IDEX_CTRL),
      .I_IDEX_ALUOP (I_IDEX_ALUOP), .I_IDEX_FLUSH (I_IDEX_FLUSH), .I_IDEX_HOLD (I_IDEX_HOLD),
      .I_WB_REGWR (I_WB_REGWR), .I_WB_RD (I_WB_RD), .I_WB_DATA (I_WB_DATA),
      .O_IDEX_STALL (O_IDEX_STALL), .O_IDEX_VALID (O_IDEX_VALID),
      .O_IDEX_A (O_IDEX_A), .O_IDEX_B (O_IDEX_B), .O_IDEX_IMM (O_IDEX_IMM),
      .O_IDEX_PC4 (O_IDEX_PC4), .O_IDEX_RS (O_IDEX_RS), .O_IDEX_RT (O_IDEX_RT),
      .O_IDEX_WREG (O_IDEX_WREG), .O_IDEX_CTRL (O_IDEX_CTRL), .O_IDEX_ALUOP (O_IDEX_ALUOP),
      .O_IDEX_STALL_CNT (O_IDEX_STALL_CNT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Behavioural view of what EX should be holding
   typedef struct {
      bit          valid;
      logic [31:0] a, b, imm, pc4;
      logic [4:0]  rs, rt, wreg;
      logic [7:0]  ctrl;
      logic [3:0]  aluop;
      int unsigned bubbles;
   } ex_t;

   ex_t m;
   int  tests_run    = 0;
   int  tests_failed = 0;
   int  cyc          = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit model_haz();
      bit dep;
      if (!m.valid || !m.ctrl[6] || m.wreg == 5'd0 || !I_IDEX_VALID) return 1'b0;
      dep = (m.wreg == I_IDEX_RS) || (I_IDEX_USES_RT && m.wreg == I_IDEX_RT);
      return dep;
   endfunction

   function automatic logic [31:0] bypassed(input logic [4:0] src, input logic [31:0] rf);
`ifdef IDEX_WB_BYPASS_EN
      if (I_WB_REGWR && I_WB_RD != 5'd0 && I_WB_RD == src) return I_WB_DATA;
`endif
      return rf;
   endfunction

   function automatic ex_t model_next(input bit haz);
      ex_t n;
      n = m;
      if (RESET) begin
         n.valid = 0; n.a = 0; n.b = 0; n.imm = 0; n.pc4 = 0;
         n.rs = 0; n.rt = 0; n.wreg = 0; n.ctrl = 0; n.aluop = 0; n.bubbles = 0;
      end else if (I_IDEX_FLUSH || (!I_IDEX_HOLD && !haz)) begin
         n.a     = bypassed(I_IDEX_RS, I_IDEX_READ_DATA_1);
         n.b     = bypassed(I_IDEX_RT, I_IDEX_READ_DATA_2);
         n.imm   = I_IDEX_IMM;
         n.pc4   = I_IDEX_PC4;
         n.rs    = I_IDEX_RS;
         n.rt    = I_IDEX_RT;
         n.wreg  = I_IDEX_CTRL[2] ? I_IDEX_RD : I_IDEX_RT;
         n.valid = I_IDEX_FLUSH ? 1'b0 : I_IDEX_VALID;
         n.ctrl  = n.valid ? I_IDEX_CTRL : 8'h00;
         n.aluop = I_IDEX_FLUSH ? 4'h0 : I_IDEX_ALUOP;
      end else if (!I_IDEX_HOLD) begin
         n.valid = 0; n.ctrl = 0; n.aluop = 0;
         if (n.bubbles < 65535) n.bubbles = n.bubbles + 1;
      end
      return n;
   endfunction

   // One clock: combinational stall check before the edge, registered outputs checked on the negedge
   task automatic do_cycle(input bit chk_stall);
      bit  haz;
      ex_t nxt;
      #1;
      haz = model_haz();
      if (chk_stall) check_val("stall", O_IDEX_STALL, haz | I_IDEX_HOLD);
      nxt = model_next(haz);
      @(posedge CLK);
      m = nxt;
      @(negedge CLK);
      cyc++;
      check_val("valid", O_IDEX_VALID, m.valid);
      check_val("ctrl", O_IDEX_CTRL, m.ctrl);
      check_val("aluop", O_IDEX_ALUOP, m.aluop);
      check_val("stall_cnt", O_IDEX_STALL_CNT, m.bubbles);
      if (m.valid) begin
         check_val("a", O_IDEX_A, m.a);
         check_val("b", O_IDEX_B, m.b);
         check_val("imm", O_IDEX_IMM, m.imm);
         check_val("pc4", O_IDEX_PC4, m.pc4);
         check_val("rs", O_IDEX_RS, m.rs);
         check_val("rt", O_IDEX_RT, m.rt);
         check_val("wreg", O_IDEX_WREG, m.wreg);
      end
      $display("[TB] cyc %0d rst=%0b fl=%0b hold=%0b v=%0b rs=%0d wreg=%0d ctrl=%h cnt=%0d",
               cyc, RESET, I_IDEX_FLUSH, I_IDEX_HOLD, O_IDEX_VALID, O_IDEX_RS,
               O_IDEX_WREG, O_IDEX_CTRL, O_IDEX_STALL_CNT);
   endtask

   task automatic set_instr(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input bit uses_rt, input logic [7:0] ctrl);
      I_IDEX_VALID       = v;
      I_IDEX_RS          = rs;
      I_IDEX_RT          = rt;
      I_IDEX_RD          = rd;
      I_IDEX_USES_RT     = uses_rt;
      I_IDEX_CTRL        = ctrl;
      I_IDEX_ALUOP       = 4'($urandom_range(0, 15));
      I_IDEX_READ_DATA_1 = $urandom;
      I_IDEX_READ_DATA_2 = $urandom;
      I_IDEX_IMM         = $urandom;
      I_IDEX_PC4         = $urandom;
   endtask

   localparam logic [7:0] C_LW   = 8'b1101_1000; // REGWR MEMRD MEMTOREG ALUSRC, dest = RT
   localparam logic [7:0] C_ADD  = 8'b1000_0100; // REGWR REGDST
   localparam logic [7:0] C_ADDI = 8'b1000_1000; // REGWR ALUSRC
   localparam logic [7:0] C_BEQ  = 8'b0000_0010;

   initial begin
      RESET = 1'b1; I_IDEX_FLUSH = 0; I_IDEX_HOLD = 0;
      I_WB_REGWR = 0; I_WB_RD = 0; I_WB_DATA = 0;
      set_instr(0, 0, 0, 0, 0, 8'h00);
      m = '{valid: 0, a: 0, b: 0, imm: 0, pc4: 0, rs: 0, rt: 0, wreg: 0,
            ctrl: 0, aluop: 0, bubbles: 0};

      // Reset held two cycles; state is unknown before the first edge
      do_cycle(0);
      do_cycle(1);
      RESET = 0;
      #1;
      check_val("rst_stall", O_IDEX_STALL, 1'b0);
      check_val("rst_a", O_IDEX_A, 32'h0);
      check_val("rst_wreg", O_IDEX_WREG, 5'h0);
      check_val("rst_pc4", O_IDEX_PC4, 32'h0);
      @(negedge CLK);

      // lw $8,0($9) ; add $10,$8,$11
      set_instr(1, 5'd9, 5'd8, 5'd0, 0, C_LW);     do_cycle(1);
      set_instr(1, 5'd8, 5'd11, 5'd10, 1, C_ADD);  do_cycle(1);
      check_val("lu_bubble", O_IDEX_VALID, 1'b0);
      check_val("lu_cnt", O_IDEX_STALL_CNT, 16'd1);
      do_cycle(1);
      check_val("lu_add_rs", O_IDEX_RS, 5'd8);

      // lw $0 then use $0; lw $8 then addi with RT=8 unused
      set_instr(1, 5'd9, 5'd0, 5'd0, 0, C_LW);     do_cycle(1);
      set_instr(1, 5'd0, 5'd0, 5'd3, 1, C_ADD);    do_cycle(1);
      set_instr(1, 5'd9, 5'd8, 5'd0, 0, C_LW);     do_cycle(1);
      set_instr(1, 5'd13, 5'd8, 5'd0, 0, C_ADDI);  do_cycle(1);
      check_val("no_stall_cnt", O_IDEX_STALL_CNT, 16'd1);

      // Flush of a branch-shadow instruction, then flush together with hold
      set_instr(1, 5'd1, 5'd2, 5'd3, 1, C_BEQ); I_IDEX_FLUSH = 1; do_cycle(1);
      set_instr(1, 5'd4, 5'd5, 5'd6, 1, C_ADD); do_cycle(1);
      I_IDEX_FLUSH = 0;
      set_instr(1, 5'd4, 5'd5, 5'd6, 1, C_ADD); do_cycle(1);
      I_IDEX_HOLD = 1; I_IDEX_FLUSH = 1;        do_cycle(1);
      check_val("holdflush_v", O_IDEX_VALID, 1'b0);
      I_IDEX_HOLD = 0; I_IDEX_FLUSH = 0;

      // Hold three cycles with A=0x1234 in EX
      set_instr(1, 5'd7, 5'd6, 5'd5, 1, C_ADD); I_IDEX_READ_DATA_1 = 32'h1234; do_cycle(1);
      I_IDEX_HOLD = 1;
      for (int i = 0; i < 3; i++) begin
         set_instr(1, 5'd3, 5'd2, 5'd1, 1, C_ADD);
         do_cycle(1);
      end
      check_val("hold_a", O_IDEX_A, 32'h1234);
      I_IDEX_HOLD = 0;

      // Reset while a load-use stall is pending
      set_instr(1, 5'd9, 5'd8, 5'd0, 0, C_LW);    do_cycle(1);
      set_instr(1, 5'd8, 5'd1, 5'd2, 1, C_ADD); RESET = 1; do_cycle(1);
      RESET = 0; do_cycle(1);

      // Same-cycle writeback of $5 while ID reads stale $5
      set_instr(1, 5'd5, 5'd6, 5'd7, 1, C_ADD);
      I_IDEX_READ_DATA_1 = 32'h0;
      I_WB_REGWR = 1; I_WB_RD = 5'd5; I_WB_DATA = 32'hDEADBEEF;
      do_cycle(1);
`ifdef IDEX_WB_BYPASS_EN
      check_val("bypass_a", O_IDEX_A, 32'hDEADBEEF);
`else
      check_val("bypass_a", O_IDEX_A, 32'h0);
`endif
      I_WB_REGWR = 0;

      // Random traffic on a tiny register range so hazards are frequent
      for (int i = 0; i < 400; i++) begin
         logic [7:0] c;
         c = 8'($urandom);
         if ($urandom_range(0, 1) == 1) c[6] = 1'b1;
         set_instr($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), c);
         I_IDEX_FLUSH = ($urandom_range(0, 9) == 0);
         I_IDEX_HOLD  = ($urandom_range(0, 6) == 0);
         RESET        = ($urandom_range(0, 49) == 0);
         I_WB_REGWR   = 1'($urandom_range(0, 1));
         I_WB_RD      = 5'($urandom_range(0, 3));
         I_WB_DATA    = $urandom;
         do_cycle(1);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
